onehot_decoder_seq: RTL and testbench

- Parametrised, registered successor of the team's 1-to-2 enable decoder (y0 = e & ~a, y1 = e & a).
- Generalises that decoder to SEL_W-to-2^SEL_W one-hot decoding with a registered output.
- Adds a SCAN mode in which an internal prescaled counter walks the active output across all lines.
- Used as a display/row-select driver and as a lab reference block.

---
 rtl/onehot_decoder_seq_pkg.sv | 24 ++
 rtl/onehot_decoder_seq_if.sv | 54 +++++
 rtl/onehot_decoder_seq_scan_tick_gen.sv | 40 ++++
 rtl/onehot_decoder_seq.sv | 113 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_decoder_seq_pkg.sv
// -----------------------------------------------------------------------------
// onehot_pkg
// Shared types and helpers for the onehot_decoder_seq block.
//   mode_e      : FSM state / operating mode (DECODE, SCAN)
//   MAX_SEL_W   : widest select the onehot() helper supports
//   onehot(idx) : returns 1 << idx at MAX_OUT_W width; callers cast the
//                 result down to their own OUT_W
// Optional build macro used by files importing this package: SCAN_BIDIR_EN.
// -----------------------------------------------------------------------------
package onehot_pkg;

    typedef enum logic {
        MODE_DECODE = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        return MAX_OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq_if
// Signal bundle between a driver (master) and onehot_decoder_seq (slave).
//   en    : output enable, low forces y to zero
//   mode  : 0 = DECODE, 1 = SCAN
//   a     : select index (DECODE) / seed index on entry to SCAN
//   div   : SCAN dwell, index advances every div+1 enabled cycles
//   dir   : SCAN direction, 1 = count down (only when SCAN_BIDIR_EN defined)
//   y     : registered one-hot (or zero) output
//   idx   : registered current index
//   wrap  : one-cycle pulse when the SCAN index wraps
//   state : registered FSM state, exposed for observation
//
// Handshake: there is no valid/ready pair. Every rising clk edge samples all
// master-driven signals, and every slave output is a register that changes
// only on that edge (or on asynchronous reset); each cycle is one transaction.
// -----------------------------------------------------------------------------
interface onehot_decoder_seq_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
);
    import onehot_pkg::*;

    localparam int OUT_W = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] a;
    logic [DIV_W-1:0] div;
`ifdef SCAN_BIDIR_EN
    logic             dir;
`endif
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             wrap;
    mode_e            state;

    modport master (
`ifdef SCAN_BIDIR_EN
        output dir,
`endif
        output en, mode, a, div,
        input  y, idx, wrap, state
    );

    modport slave (
`ifdef SCAN_BIDIR_EN
        input  dir,
`endif
        input  en, mode, a, div,
        output y, idx, wrap, state
    );

endinterface

// File: rtl/onehot_decoder_seq_scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Prescaler for SCAN mode. Counts enabled cycles and raises tick when the
// count has reached the live divide value.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the count (highest priority)
//   run        : count this cycle
//   div        : divide value; tick every div+1 running cycles
//   tick       : combinational, run && (count >= div)
// -----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // >= rather than == so that lowering div below the current count forces
    // an advance on the next edge instead of running the counter round.
    assign tick = run && (count >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
// Registered SEL_W-to-2^SEL_W one-hot decoder with a SCAN mode that walks the
// active line across all outputs at a prescaled rate.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : onehot_decoder_seq_if.slave (en, mode, a, div, [dir] in;
//           y, idx, wrap, state out)
// Parameters: SEL_W (select width), DIV_W (prescaler divide width).
// Build macro: SCAN_BIDIR_EN adds bus.dir; dir = 1 scans downwards and wrap
// then pulses on the 0 -> OUT_W-1 step.
// -----------------------------------------------------------------------------
module onehot_decoder_seq
    import onehot_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    onehot_decoder_seq_if.slave  bus
);

    localparam int OUT_W = 2 ** SEL_W;

    function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] i);
        return OUT_W'(onehot(MAX_SEL_W'(i)));
    endfunction

    mode_e            state_q;
    logic [SEL_W-1:0] idx_q;
    logic [OUT_W-1:0] y_q;
    logic             wrap_q;

    logic             tick;
    logic             step_down;
    logic             at_wrap;
    logic [SEL_W-1:0] idx_step;
    logic [OUT_W-1:0] y_sel;
    logic             tick_clr;
    logic             tick_run;

`ifdef SCAN_BIDIR_EN
    assign step_down = bus.dir;
`else
    assign step_down = 1'b0;
`endif

    // Index arithmetic wraps naturally at SEL_W bits, i.e. modulo OUT_W.
    assign idx_step = step_down ? (idx_q - 1'b1) : (idx_q + 1'b1);
    assign at_wrap  = step_down ? (idx_q == '0) : (&idx_q);
    assign y_sel    = bus.en ? dec(bus.a) : '0;

    // Count is held at zero in DECODE and on the leaving edge; on the entry
    // edge state_q is still DECODE, so the count also starts from zero.
    assign tick_clr = (state_q == MODE_DECODE) || !bus.mode;
    assign tick_run = (state_q == MODE_SCAN) && bus.mode && bus.en;

    scan_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .run   (tick_run),
        .div   (bus.div),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_DECODE;
            idx_q   <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                MODE_DECODE: begin
                    // Also the SCAN entry edge: idx seeds from a.
                    idx_q <= bus.a;
                    y_q   <= y_sel;
                    if (bus.mode) begin
                        state_q <= MODE_SCAN;
                    end
                end
                MODE_SCAN: begin
                    if (!bus.mode) begin
                        state_q <= MODE_DECODE;
                        idx_q   <= bus.a;
                        y_q     <= y_sel;
                    end else if (!bus.en) begin
                        // Frozen: idx and prescaler hold, output blanked.
                        y_q <= '0;
                    end else if (tick) begin
                        idx_q  <= idx_step;
                        y_q    <= dec(idx_step);
                        wrap_q <= at_wrap;
                    end else begin
                        // Re-derive from idx so y recovers after a freeze.
                        y_q <= dec(idx_q);
                    end
                end
            endcase
        end
    end

    assign bus.state = state_q;
    assign bus.idx   = idx_q;
    assign bus.y     = y_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_onehot_decoder_seq
// Scoreboard bench for onehot_decoder_seq (SEL_W = 3, DIV_W = 8) plus a small
// SEL_W = 1 instance checked against the original 1-to-2 enable decoder.
// Build macro: SCAN_BIDIR_EN adds the down-scan directed sequence.
// -----------------------------------------------------------------------------
module tb_onehot_decoder_seq;
    import onehot_pkg::*;

    localparam int SEL_W = 3;
    localparam int DIV_W = 8;
    localparam int OUT_W = 8;
    localparam int EXP_W = 1 + 1 + SEL_W + OUT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    onehot_decoder_seq_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();
    onehot_decoder_seq_if #(.SEL_W(1), .DIV_W(DIV_W)) bus1 ();

    onehot_decoder_seq #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    onehot_decoder_seq #(.SEL_W(1), .DIV_W(DIV_W)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Spec-level view: a scan position (0..7), a dwell counter and a mode flag.
    bit m_scan = 0;
    int m_idx  = 0;
    int m_cnt  = 0;

    logic [EXP_W-1:0] exp_q[$];

    task automatic model_reset();
        m_scan = 0;
        m_idx  = 0;
        m_cnt  = 0;
    endtask

    // Drive one cycle of stimulus (caller aligned at negedge), push the
    // expected post-edge response, then wait for the next negedge.
    task automatic drive(input logic e, input logic m, input int av,
                         input int dv, input logic dr);
        logic [OUT_W-1:0] ey;
        logic             ew;
        int               old;
        bit               down;
        bus.en   = e;
        bus.mode = m;
        bus.a    = SEL_W'(av);
        bus.div  = DIV_W'(dv);
`ifdef SCAN_BIDIR_EN
        bus.dir  = dr;
        down     = dr;
`else
        down     = 1'b0;
`endif
        ew = 1'b0;
        if (!m_scan || !m) begin
            m_scan = m;
            m_idx  = av;
            m_cnt  = 0;
            ey     = e ? (OUT_W'(1) << av) : '0;
        end else if (!e) begin
            ey = '0;
        end else if (m_cnt >= dv) begin
            old   = m_idx;
            m_idx = down ? (m_idx + OUT_W - 1) % OUT_W : (m_idx + 1) % OUT_W;
            m_cnt = 0;
            ew    = down ? (old == 0) : (old == OUT_W - 1);
            ey    = OUT_W'(1) << m_idx;
        end else begin
            m_cnt = m_cnt + 1;
            ey    = OUT_W'(1) << m_idx;
        end
        exp_q.push_back({m_scan, ew, SEL_W'(m_idx), ey});
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.state, bus.wrap, bus.idx, bus.y};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL sb @%0t: got state=%0d wrap=%0d idx=%0d y=%b, expected state=%0d wrap=%0d idx=%0d y=%b",
                             $time, act[EXP_W-1], act[EXP_W-2], act[OUT_W +: SEL_W], act[OUT_W-1:0],
                             e[EXP_W-1], e[EXP_W-2], e[OUT_W +: SEL_W], e[OUT_W-1:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic e1;
        logic a1;
        logic rm;
        bus.en = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.div = '0;
        bus1.en = 1'b0; bus1.mode = 1'b0; bus1.a = '0; bus1.div = '0;
`ifdef SCAN_BIDIR_EN
        bus.dir = 1'b0;
        bus1.dir = 1'b0;
`endif

        // 1. reset values and DECODE latency
        repeat (2) @(negedge clk);
        check("rst_y", int'(bus.y), 0);
        check("rst_idx", int'(bus.idx), 0);
        check("rst_wrap", int'(bus.wrap), 0);
        check("rst_state", int'(bus.state), int'(MODE_DECODE));
        rst_n = 1'b1;
        model_reset();
        drive(1, 0, 5, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 3, 0, 0);
        drive(1, 0, 7, 0, 0);

        // 3. scan timing and wrap: 6 x3, 7 x3, then 0
        for (int i = 0; i < 9; i++) drive(1, 1, 6, 2, 0);

        // 4. walk to idx 3 / count 1, freeze 5 cycles, resume with div 0
        n = 0;
        while (!(m_idx == 3 && m_cnt == 1) && n < 40) begin
            drive(1, 1, 0, 2, 0);
            n++;
        end
        check("reach_idx3_cnt1", int'(m_idx == 3 && m_cnt == 1), 1);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 2, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0);

        // live div lowered below count forces an advance
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 7, 0);
        drive(1, 1, 0, 1, 0);

        // 5. SCAN -> DECODE, then async reset between edges mid-scan
        drive(1, 0, 2, 0, 0);
        drive(1, 1, 4, 1, 0);
        drive(1, 1, 4, 1, 0);
        drive(1, 1, 4, 1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_y", int'(bus.y), 0);
        check("async_rst_idx", int'(bus.idx), 0);
        check("async_rst_state", int'(bus.state), int'(MODE_DECODE));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1, 0, 6, 0, 0);
        drive(1, 0, 1, 0, 0);

`ifdef SCAN_BIDIR_EN
        // 6. down scan: 1, 0, 7, 6 with wrap on 0 -> 7
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 1);
        drive(1, 0, 0, 0, 0);
`endif

        // randomized traffic, mode kept sticky so SCAN runs are long
        rm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15, 0) == 0) rm = ~rm;
            drive(($urandom_range(7, 0) != 0), rm, int'($urandom_range(7, 0)),
                  int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end
        drain();

        // 2. SEL_W = 1 equivalence with y0 = e & ~a, y1 = e & a
        for (int i = 0; i < 12; i++) begin
            e1 = (i < 4) ? 1'(i >> 1) : 1'($urandom_range(1, 0));
            a1 = (i < 4) ? 1'(i) : 1'($urandom_range(1, 0));
            bus1.en = e1;
            bus1.a  = a1;
            @(posedge clk);
            #1;
            check("sel1_y", int'(bus1.y), int'({e1 & a1, e1 & ~a1}));
            @(negedge clk);
        end

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
